// File: rtl/mem_access_pkg.sv
// Shared types for the data-memory access stage.
// Holds the read FSM encoding and the one-entry store buffer record.
package mem_access_pkg;

    localparam int unsigned MAU_NBITS = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } mau_state_t;

    typedef struct packed {
        logic                 valid;
        logic [MAU_NBITS-1:0] addr;
        logic [MAU_NBITS-1:0] data;
    } wbuf_t;

endpackage

// File: rtl/mem_write_buffer.sv
// One-entry posted-store buffer with address-compare forwarding.
// Latency: capture on the accepting edge, contents visible the next cycle.
// Backpressure: the owner must only write while empty; drain_ack frees the entry.
module mem_write_buffer
    import mem_access_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_vld,
    input  logic [MAU_NBITS-1:0] wr_addr,
    input  logic [MAU_NBITS-1:0] wr_dat,
    input  logic                 drain_ack,
    input  logic [MAU_NBITS-1:0] lookup_addr,
    output logic                 wb_vld,
    output logic [MAU_NBITS-1:0] wb_addr,
    output logic [MAU_NBITS-1:0] wb_dat,
    output logic                 fwd_hit
);

    wbuf_t wb_q, wb_d;

    always_comb begin
        wb_d = wb_q;
        if (drain_ack) begin
            wb_d.valid = 1'b0;
        end
        if (wr_vld) begin
            wb_d.valid = 1'b1;
            wb_d.addr  = wr_addr;
            wb_d.data  = wr_dat;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign wb_vld  = wb_q.valid;
    assign wb_addr = wb_q.addr;
    assign wb_dat  = wb_q.data;
    assign fwd_hit = wb_q.valid && (wb_q.addr == lookup_addr);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage between the controller and a single-port req/ack data memory.
// Latency: stores post with zero stall; loads stall until ack plus one cycle, buffer hits forward at once.
// Backpressure: busy holds the controller while the buffer is full or a read is outstanding.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int NBITS = MAU_NBITS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [NBITS-1:0] addr,
    input  logic [NBITS-1:0] wdata,
    output logic [NBITS-1:0] rdata,
    output logic             busy,
    output logic             err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [NBITS-1:0] mem_addr,
    output logic [NBITS-1:0] mem_wdata,
    input  logic [NBITS-1:0] mem_rdata,
    input  logic             mem_ack
);

    mau_state_t       state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [NBITS-1:0] mem_addr_q, mem_addr_d;
    logic [NBITS-1:0] mem_wdata_q, mem_wdata_d;
    logic [NBITS-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             wb_vld, fwd_hit;
    logic [NBITS-1:0] wb_addr, wb_dat;
    logic             is_load, store_acc, fwd, ack_vld, drain_ack, drain_issue, rd_issue;
    logic             busy_raw;

    // A simultaneous read+write request is handled purely as a store.
    assign is_load     = MemRead && !MemWrite;
    assign store_acc   = MemWrite && !wb_vld;
    assign fwd         = is_load && fwd_hit;
    assign ack_vld     = mem_ack && mem_req_q;
    assign drain_ack   = ack_vld && mem_we_q;
    assign drain_issue = wb_vld && !mem_req_q;
    assign rd_issue    = is_load && !wb_vld && !mem_req_q && (state_q == IDLE);

    mem_write_buffer u_wbuf (
        .clock       (clock),
        .reset       (reset),
        .wr_vld      (store_acc),
        .wr_addr     (addr),
        .wr_dat      (wdata),
        .drain_ack   (drain_ack),
        .lookup_addr (addr),
        .wb_vld      (wb_vld),
        .wb_addr     (wb_addr),
        .wb_dat      (wb_dat),
        .fwd_hit     (fwd_hit)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = MemRead && MemWrite;

        if (ack_vld) begin
            mem_req_d = 1'b0;
        end
        if (drain_issue) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = wb_addr;
            mem_wdata_d = wb_dat;
        end

        case (state_q)
            IDLE: begin
                if (rd_issue) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = addr;
                    state_d    = RD_WAIT;
                end else if (fwd) begin
                    rdata_d = wb_dat;
                end
            end
            RD_WAIT: begin
                if (ack_vld && !mem_we_q) begin
                    rdata_d = mem_rdata;
                    state_d = RD_DONE;
                end
            end
            RD_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        busy_raw = 1'b0;
        if (MemWrite) begin
            busy_raw = wb_vld;
        end else if (MemRead) begin
            busy_raw = !(fwd || (state_q == RD_DONE));
        end
    end

    assign busy      = reset && busy_raw;
    assign rdata     = fwd ? wb_dat : rdata_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit with a req/ack memory model.
module tb_mem_access_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       MemRead, MemWrite;
    logic [7:0] addr, wdata, rdata;
    logic       busy, err;
    logic       mem_req, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_ack;

    int vec_cnt = 0;
    int err_cnt = 0;

    // memory model state
    logic [7:0] mem_arr [256];
    logic [7:0] ref_mem [256];
    bit         pend = 1'b0;
    bit         aborted = 1'b0;
    int         lat = 0;
    int         fixed_lat = 3;
    int         rd_cnt = 0;
    logic       p_we;
    logic [7:0] p_addr, p_wd;

    typedef struct packed {
        logic       we;
        logic [7:0] a;
        logic [7:0] d;
    } log_t;
    log_t mlog[$];

    always #5 clock = ~clock;

    mem_access_unit dut (
        .clock     (clock),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory: samples the port on the falling edge, acks after lat cycles.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clock);
            mem_ack = 1'b0;
            if (pend) begin
                if (reset !== 1'b1) aborted = 1'b1;
                if (!aborted)
                    check("req_stable", {14'd0, mem_req, mem_we, mem_addr, mem_wdata},
                          {14'd0, 1'b1, p_we, p_addr, p_wd});
                lat--;
                if (lat == 0) begin
                    mem_ack = 1'b1;
                    pend    = 1'b0;
                    if (p_we) mem_arr[p_addr] = p_wd;
                    else      mem_rdata = mem_arr[p_addr];
                    if (!aborted) mlog.push_back('{p_we, p_addr, p_we ? p_wd : mem_arr[p_addr]});
                end
            end else if (reset === 1'b1 && mem_req === 1'b1) begin
                pend    = 1'b1;
                aborted = 1'b0;
                p_we    = mem_we;
                p_addr  = mem_addr;
                p_wd    = mem_wdata;
                lat     = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(4, 1));
                if (!mem_we) rd_cnt++;
            end
        end
    end

    // One controller request held until busy drops; returns stall cycles and rdata.
    task automatic do_op(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                         output int stall, output logic [7:0] rd_val);
        @(negedge clock);
        MemRead = rd; MemWrite = wr; addr = a; wdata = d;
        stall = 0;
        #1;
        while (busy !== 1'b0 && stall < 200) begin
            @(negedge clock); #1;
            stall++;
        end
        check("op_timeout", 32'(stall < 200), 32'd1);
        rd_val = rdata;
        if (wr) ref_mem[a] = d;
        @(posedge clock); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic wait_drain();
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 100) begin
            @(negedge clock); #1;
            n++;
            if (mem_req === 1'b0 && !pend) quiet++;
            else quiet = 0;
        end
        check("drain_timeout", 32'(quiet >= 3), 32'd1);
    endtask

    initial begin
        int         st, n, lsz, rc;
        logic [7:0] rv, a, d;

        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom);
            mem_arr[i] = d;
            ref_mem[i] = d;
        end

        // reset state: requests driven but busy must stay low
        reset = 1'b0; MemRead = 1'b1; MemWrite = 1'b1; addr = 8'h55; wdata = 8'h66;
        #12;
        check("rst_rdata", rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge clock); #2 reset = 1'b1;

        // 1: posted store, zero stall, write appears on the port
        lsz = mlog.size();
        do_op(1'b0, 1'b1, 8'h10, 8'hAB, st, rv);
        check("t1_stall", st, 0);
        n = 0;
        while (mem_req !== 1'b1 && n < 10) begin @(negedge clock); #1; n++; end
        check("t1_req", mem_req, 1);
        check("t1_we", mem_we, 1);
        check("t1_addr", mem_addr, 8'h10);
        check("t1_wdata", mem_wdata, 8'hAB);
        wait_drain();
        check("t1_log", {mlog.size() == lsz + 1, mlog[mlog.size()-1]}, {1'b1, 1'b1, 8'h10, 8'hAB});

        // 2: store then load of same address forwards from the buffer
        rc = rd_cnt;
        do_op(1'b0, 1'b1, 8'h10, 8'hCD, st, rv);
        do_op(1'b1, 1'b0, 8'h10, 8'h00, st, rv);
        check("t2_stall", st, 0);
        check("t2_rdata", rv, 8'hCD);
        wait_drain();
        check("t2_no_read", rd_cnt, rc);

        // 3: load of another address waits for drain then reads memory
        mem_arr[8'h20] = 8'h5C; ref_mem[8'h20] = 8'h5C;
        lsz = mlog.size();
        do_op(1'b0, 1'b1, 8'h10, 8'hAB, st, rv);
        do_op(1'b1, 1'b0, 8'h20, 8'h00, st, rv);
        check("t3_stalled", 32'(st > 0), 1);
        check("t3_rdata", rv, 8'h5C);
        wait_drain();
        check("t3_nlog", mlog.size(), lsz + 2);
        check("t3_first_wr", mlog[lsz], {1'b1, 8'h10, 8'hAB});
        check("t3_then_rd", mlog[lsz+1], {1'b0, 8'h20, 8'h5C});

        // 4: back-to-back stores, second waits for first ack
        lsz = mlog.size();
        do_op(1'b0, 1'b1, 8'h01, 8'h11, st, rv);
        check("t4_first_stall", st, 0);
        do_op(1'b0, 1'b1, 8'h02, 8'h22, st, rv);
        check("t4_second_stalled", 32'(st > 0), 1);
        wait_drain();
        check("t4_order0", mlog[lsz], {1'b1, 8'h01, 8'h11});
        check("t4_order1", mlog[lsz+1], {1'b1, 8'h02, 8'h22});
        check("t4_mem", {mem_arr[1], mem_arr[2]}, 16'h1122);

        // 5: reset during an outstanding read, then a late ack
        fixed_lat = 6;
        @(negedge clock); MemRead = 1'b1; addr = 8'h44;
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("t5_rdata", rdata, 0);
        check("t5_req", mem_req, 0);
        check("t5_addr", mem_addr, 0);
        check("t5_busy", busy, 0);
        check("t5_err", err, 0);
        MemRead = 1'b0;
        @(negedge clock); #2 reset = 1'b1;
        n = 0;
        while (pend && n < 20) begin @(negedge clock); n++; end
        check("t5_late_ack_seen", 32'(pend), 0);
        @(posedge clock); #1;
        check("t5_ack_ignored_req", mem_req, 0);
        check("t5_ack_ignored_rdata", rdata, 0);
        fixed_lat = 3;
        do_op(1'b1, 1'b0, 8'h44, 8'h00, st, rv);
        check("t5_reload", rv, ref_mem[8'h44]);

        // 6: read and write together is an error and a store only
        wait_drain();
        rc = rd_cnt;
        do_op(1'b1, 1'b1, 8'h30, 8'h77, st, rv);
        check("t6_stall", st, 0);
        check("t6_err_hi", err, 1);
        @(posedge clock); #1;
        check("t6_err_lo", err, 0);
        wait_drain();
        check("t6_store", mlog[mlog.size()-1], {1'b1, 8'h30, 8'h77});
        check("t6_no_read", rd_cnt, rc);

        // random loads/stores over a small address window
        fixed_lat = 0;
        for (int k = 0; k < 60; k++) begin
            a = 8'($urandom_range(7, 0));
            d = 8'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                do_op(1'b0, 1'b1, a, d, st, rv);
            end else begin
                do_op(1'b1, 1'b0, a, 8'h00, st, rv);
                check("rand_load", rv, ref_mem[a]);
            end
        end
        wait_drain();
        for (int i = 0; i < 8; i++) begin
            check("final_mem", mem_arr[i], ref_mem[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage directly downstream of the controller's MemRead/MemWrite/busy interface.
- Accepts load/store requests from the controller/datapath and drives a single-port data memory with a req/ack handshake of unknown latency.
- Stores are posted through a one-entry write buffer. Loads stall the controller via busy until data is available.
- A load that hits the buffered store is forwarded without touching memory.

Parameters:
- NBITS, 8, data and address width; matches controller NBITS.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- MemRead  in  1  load request from controller, held until busy=0
- MemWrite  in  1  store request from controller, held until busy=0
- addr  in  NBITS  byte address (ALU result)
- wdata  in  NBITS  store data (RS2 value)
- rdata  out  NBITS  load data, valid in the cycle a load completes (busy=0 with MemRead=1)
- busy  out  1  combinational stall to controller
- err  out  1  one-cycle pulse: MemRead and MemWrite both high
- mem_req  out  1  memory request, registered
- mem_we  out  1  1=write, 0=read, registered
- mem_addr  out  NBITS  registered
- mem_wdata  out  NBITS  registered
- mem_rdata  in  NBITS  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse from memory

Behaviour:
- Reset (reset=0, async) gives:
  - state IDLE, write buffer empty (wb_valid=0);
  - rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0;
  - busy forced 0 while reset is low.
- Reset mid-transaction drops the outstanding read and any buffered store. Memory acks arriving afterwards with mem_req=0 are ignored.
- States:
  - IDLE: no read in flight.
  - RD_WAIT: read issued, waiting for mem_ack.
  - RD_DONE: one cycle, presents captured data.
- Write buffer: wb_valid, wb_addr, wb_data. Draining is independent of the state FSM but shares the memory port. The buffer drains when not empty and the port is free:
  - a write request is issued (mem_req=1, mem_we=1, mem_addr=wb_addr, mem_wdata=wb_data) on the clock after capture;
  - on mem_ack, wb_valid clears.
- Store, buffer empty: captured at the clock edge; busy=0 in the request cycle (zero stall).
- Store, buffer full: busy=1 until the drain ack. The store is accepted in the first cycle with wb_valid=0.
- Load, buffer valid with wb_addr==addr: forward. rdata=wb_data combinationally, busy=0, no memory access.
- Load, buffer valid with a different address: busy=1 while draining. After the drain ack the read is issued (ordering preserved).
- Load, buffer empty, state IDLE, at clock edge:
  - mem_req=1, mem_we=0, mem_addr=addr; state goes to RD_WAIT; busy=1 in the request cycle.
  - RD_WAIT with mem_ack: rdata register <= mem_rdata, mem_req<=0, state goes to RD_DONE; busy=1 in this cycle.
  - RD_DONE: busy=0, rdata holds the captured value, and the held MemRead is treated as consumed (no reissue). Next state is IDLE.
- Load latency: memory ack on clock k after issue gives busy low on cycle k+2 after the request cycle.
- rdata keeps its last value when not loading.
- Memory-side rules:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable from issue until the ack cycle.
  - At most one outstanding request.
  - mem_ack while mem_req=0 is ignored.
  - mem_req drops the cycle after the ack; back-to-back issue is allowed on the following edge.
- MemRead & MemWrite both high:
  - err=1 for each such cycle (registered, next cycle);
  - the request is treated as a store only.
- Neither request high: busy=0 (except while reset is high, busy reflects requests only).

Decomposition:
- Package mem_access_pkg holds:
  - typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} mau_state_t;
  - typedef struct {valid, addr, data} wbuf_t.
- Optional sub-module: mem_write_buffer (one-entry store buffer with drain handshake and address-compare forward). FSM and port arbitration stay in mem_access_unit.

Test Plan:
1. Memory model acks 3 cycles after req. Store addr=0x10 wdata=0xAB → busy=0 in the request cycle; mem_req/mem_we=1, mem_addr=0x10 on the next cycle; wb_valid clears after the ack.
2. Store 0x10=0xAB immediately followed by load 0x10 → busy=0, rdata=0xAB, no read on mem_req.
3. Store 0x10=0xAB, then load 0x20 (memory holds 0x5C) → busy high through the drain and the read; write issued before read; rdata=0x5C when busy falls.
4. Two back-to-back stores (0x01=0x11, 0x02=0x22) → second store sees busy=1 until the first ack, then zero-stall. Memory ends with both values, in order.
5. Load issued, reset pulled low during RD_WAIT, then a late mem_ack → all outputs 0, busy=0, the ack is ignored, and a subsequent load completes normally.
6. MemRead=MemWrite=1 with addr=0x30, wdata=0x77 → err pulses 1 for one cycle; a store is performed; no read is issued.
